// File: rtl/rv_test_pkg.sv
// Shared types and constants for the RV32I self-checking test monitor.
package rv_test_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_VERDICT  = 3'd2,
        ST_DUMP     = 3'd3,
        ST_FINISHED = 3'd4
    } mon_state_t;

    localparam int RV32_NREGS = 32;
    localparam int RV32_AW    = $clog2(RV32_NREGS);

    // riscv-tests convention: x26 = done, x27 = pass flag, x3 (gp) = test number
    localparam int DEFAULT_DONE_REG = 26;
    localparam int DEFAULT_PASS_REG = 27;
    localparam int DEFAULT_TNUM_REG = 3;

endpackage

// File: rtl/rv_shadow_regfile.sv
// Shadow copy of the architectural register file, fed from the core's write-back port.
// x0 is never stored and always reads 0; freeze blocks all writes.
module rv_shadow_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [XLEN-1:0]          i_wdata,
    input  logic                     i_freeze,
    input  logic [$clog2(NREGS)-1:0] i_raddr_a,
    output logic [XLEN-1:0]          o_rdata_a,
    input  logic [$clog2(NREGS)-1:0] i_raddr_b,
    output logic [XLEN-1:0]          o_rdata_b
);

    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && !i_freeze && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_mem[i_raddr_b];

endmodule

// File: rtl/rv_test_monitor.sv
// Pass/fail monitor for RV32I self-checking programs: mirrors register write-back,
// waits for the done marker, settles, issues a verdict and dumps registers on failure.
module rv_test_monitor
    import rv_test_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NREGS          = RV32_NREGS,
    parameter int DONE_REG       = DEFAULT_DONE_REG,
    parameter int PASS_REG       = DEFAULT_PASS_REG,
    parameter int TNUM_REG       = DEFAULT_TNUM_REG,
    parameter int SETTLE_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we_i,
    input  logic [$clog2(NREGS)-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]          wb_wdata_i,
    input  logic                     retire_i,
    output logic                     verdict_valid_o,
    output logic                     pass_o,
    output logic                     timeout_o,
    output logic [XLEN-1:0]          fail_testnum_o,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic [CNT_W-1:0]         retire_cnt_o,
    output logic                     halt_req_o,
    output logic                     dump_valid_o,
    input  logic                     dump_ready_i,
    output logic [$clog2(NREGS)-1:0] dump_idx_o,
    output logic [XLEN-1:0]          dump_data_o,
    output logic                     dump_last_o,
    output mon_state_t               dbg_state_o
);

    localparam int AW = $clog2(NREGS);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [AW-1:0]    DONE_IDX    = AW'(DONE_REG);
    localparam logic [AW-1:0]    PASS_IDX    = AW'(PASS_REG);
    localparam logic [AW-1:0]    TNUM_IDX    = AW'(TNUM_REG);
    localparam logic [AW-1:0]    LAST_IDX    = AW'(NREGS - 1);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam bit               WDOG_EN     = (TIMEOUT_CYCLES != 0);

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic [SW-1:0]    r_settle;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retire_cnt;
    logic [AW-1:0]    r_dump_idx;
    logic             r_verdict_valid;
    logic             r_pass;
    logic             r_timeout;
    logic [XLEN-1:0]  r_fail_tnum;

    logic            w_done_wr;
    logic            w_wdog;
    logic            w_counting;
    logic            w_verdict_pass;
    logic            w_dump_hs;
    logic            w_dump_last;
    logic [AW-1:0]   w_rd_b_addr;
    logic [XLEN-1:0] w_rd_a_data;
    logic [XLEN-1:0] w_rd_b_data;

    // Read port B serves the test number during VERDICT and the dump index during DUMP.
    assign w_rd_b_addr = (r_state == ST_DUMP) ? r_dump_idx : TNUM_IDX;

    rv_shadow_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst),
        .i_we      (wb_we_i),
        .i_waddr   (wb_waddr_i),
        .i_wdata   (wb_wdata_i),
        .i_freeze  (r_verdict_valid),
        .i_raddr_a (PASS_IDX),
        .o_rdata_a (w_rd_a_data),
        .i_raddr_b (w_rd_b_addr),
        .o_rdata_b (w_rd_b_data)
    );

    assign w_done_wr      = wb_we_i && (wb_waddr_i == DONE_IDX) && (wb_wdata_i == XLEN'(1));
    assign w_wdog         = WDOG_EN && (r_cycle_cnt == TO_LAST);
    assign w_counting     = (r_state == ST_RUN) || (r_state == ST_SETTLE);
    assign w_verdict_pass = (w_rd_a_data == XLEN'(1)) && !r_timeout;
    assign w_dump_last    = (r_dump_idx == LAST_IDX);
    // Dump handshake: a beat transfers on a rising clk edge where dump_valid_o && dump_ready_i;
    // while valid is high and ready is low, idx/data/last stay unchanged (shadow is frozen).
    assign w_dump_hs      = (r_state == ST_DUMP) && dump_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_done_wr) begin
                    w_state_nxt = ST_SETTLE;
                end else if (w_wdog) begin
                    w_state_nxt = ST_VERDICT;
                end
            end
            ST_SETTLE: begin
                if (r_settle == '0) begin
                    w_state_nxt = ST_VERDICT;
                end
            end
            ST_VERDICT:  w_state_nxt = w_verdict_pass ? ST_FINISHED : ST_DUMP;
            ST_DUMP: begin
                if (w_dump_hs && w_dump_last) begin
                    w_state_nxt = ST_FINISHED;
                end
            end
            ST_FINISHED: w_state_nxt = ST_FINISHED;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_settle        <= '0;
            r_cycle_cnt     <= '0;
            r_retire_cnt    <= '0;
            r_dump_idx      <= '0;
            r_verdict_valid <= 1'b0;
            r_pass          <= 1'b0;
            r_timeout       <= 1'b0;
            r_fail_tnum     <= '0;
        end else begin
            if (w_counting && (r_cycle_cnt != CNT_MAX)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_counting && retire_i && (r_retire_cnt != CNT_MAX)) begin
                r_retire_cnt <= r_retire_cnt + 1'b1;
            end
            if ((r_state == ST_RUN) && w_done_wr) begin
                r_settle <= SETTLE_LOAD;
            end else if ((r_state == ST_SETTLE) && (r_settle != '0)) begin
                r_settle <= r_settle - 1'b1;
            end
            // A done write in the same cycle takes priority over the watchdog.
            if ((r_state == ST_RUN) && !w_done_wr && w_wdog) begin
                r_timeout <= 1'b1;
            end
            if (r_state == ST_VERDICT) begin
                r_verdict_valid <= 1'b1;
                r_pass          <= w_verdict_pass;
                r_fail_tnum     <= w_rd_b_data;
            end
            if (w_dump_hs && !w_dump_last) begin
                r_dump_idx <= r_dump_idx + 1'b1;
            end
        end
    end

    assign verdict_valid_o = r_verdict_valid;
    assign halt_req_o      = r_verdict_valid;
    assign pass_o          = r_pass;
    assign timeout_o       = r_timeout;
    assign fail_testnum_o  = r_fail_tnum;
    assign cycle_cnt_o     = r_cycle_cnt;
    assign retire_cnt_o    = r_retire_cnt;
    assign dump_valid_o    = (r_state == ST_DUMP);
    assign dump_idx_o      = dump_valid_o ? r_dump_idx : '0;
    assign dump_data_o     = dump_valid_o ? w_rd_b_data : '0;
    assign dump_last_o     = dump_valid_o && w_dump_last;
    assign dbg_state_o     = r_state;

endmodule
